// File: rtl/wb_write_queue_if.sv
// -----------------------------------------------------------------------------
// wb_write_queue_if
// Bundle of the writeback-queue bus signals.
//   master : request sources (A = ALU, B = memory), stall, forwarding lookups
//   slave  : the queue itself (ready flags, register-file write, forwarding
//            results, occupancy count)
// DEPTH must match the DEPTH of the wb_write_queue it is connected to.
// -----------------------------------------------------------------------------
interface wb_write_queue_if #(
    parameter int DEPTH = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Request source A (older)
    logic             ValidA;
    logic [3:0]       RegA;
    logic [15:0]      DataA;
    logic             ReadyA;
    // Request source B (younger)
    logic             ValidB;
    logic [3:0]       RegB;
    logic [15:0]      DataB;
    logic             ReadyB;
    // Register-file write port
    logic             Stall;
    logic             WriteReg;
    logic [3:0]       DstReg;
    logic [15:0]      DstData;
    // Forwarding lookups
    logic [3:0]       SrcReg1;
    logic [3:0]       SrcReg2;
    logic             FwdHit1;
    logic             FwdHit2;
    logic [15:0]      FwdData1;
    logic [15:0]      FwdData2;
    // Occupancy
    logic [CNT_W-1:0] Count;

    modport master (
        output ValidA, RegA, DataA, ValidB, RegB, DataB, Stall, SrcReg1, SrcReg2,
        input  ReadyA, ReadyB, WriteReg, DstReg, DstData,
               FwdHit1, FwdHit2, FwdData1, FwdData2, Count
    );

    modport slave (
        input  ValidA, RegA, DataA, ValidB, RegB, DataB, Stall, SrcReg1, SrcReg2,
        output ReadyA, ReadyB, WriteReg, DstReg, DstData,
               FwdHit1, FwdHit2, FwdData1, FwdData2, Count
    );
endinterface

// File: rtl/wb_write_queue.sv
// -----------------------------------------------------------------------------
// wb_write_queue
// Circular writeback queue between two result sources and a single
// register-file write port, with register forwarding from pending entries.
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : wb_write_queue_if.slave
//          ValidA/RegA/DataA/ReadyA  - request A (older source)
//          ValidB/RegB/DataB/ReadyB  - request B (younger source)
//          Stall                     - write port busy this cycle
//          WriteReg/DstReg/DstData   - register-file write (head entry)
//          SrcReg1/2 -> FwdHit1/2, FwdData1/2 - youngest pending data lookup
//          Count                     - occupied entries
// Writes to R0 are accepted but discarded and never occupy an entry.
// -----------------------------------------------------------------------------
module wb_write_queue #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    wb_write_queue_if.slave        bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [3:0]       regMem  [DEPTH];
    logic [15:0]      dataMem [DEPTH];
    logic [PTR_W-1:0] headPtr;
    logic [PTR_W-1:0] tailPtr;
    logic [CNT_W-1:0] count;

    logic             readyA;
    logic             readyB;
    logic             keepA;
    logic             keepB;
    logic [1:0]       enqCount;
    logic             deq;
    logic [PTR_W-1:0] slotB;

    // Readiness looks only at the registered count, so a slot freed by a
    // dequeue this cycle cannot be refilled until the next cycle.
    assign readyA   = count < CNT_W'(DEPTH);
    assign readyB   = count < CNT_W'(DEPTH - 1);

    // Accepted R0 requests complete the handshake but are dropped here.
    assign keepA    = bus.ValidA && readyA && (bus.RegA != 4'd0);
    assign keepB    = bus.ValidB && readyB && (bus.RegB != 4'd0);
    assign enqCount = {1'b0, keepA} + {1'b0, keepB};
    assign deq      = (count != '0) && !bus.Stall;

    // B follows A when both are kept; otherwise B takes the tail slot.
    assign slotB    = keepA ? tailPtr + PTR_W'(1) : tailPtr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (deq) begin
                headPtr <= headPtr + PTR_W'(1);
            end
            tailPtr <= tailPtr + PTR_W'(enqCount);
            count   <= count + CNT_W'(enqCount) - CNT_W'(deq);
        end
    end

    // NOTE: the storage array has no reset; occupancy masks every read, so
    // stale contents are never visible.
    always_ff @(posedge clk) begin
        if (keepA) begin
            regMem[tailPtr]  <= bus.RegA;
            dataMem[tailPtr] <= bus.DataA;
        end
        if (keepB) begin
            regMem[slotB]  <= bus.RegB;
            dataMem[slotB] <= bus.DataB;
        end
    end

    // Forwarding scan from oldest to youngest, so the last match wins.
    logic [PTR_W-1:0] scanIdx;
    logic             fwdHit1;
    logic             fwdHit2;
    logic [15:0]      fwdData1;
    logic [15:0]      fwdData2;

    // NOTE: every always_comb output gets a default first so no path can
    // leave a value held, which would infer a latch.
    always_comb begin
        scanIdx  = '0;
        fwdHit1  = 1'b0;
        fwdHit2  = 1'b0;
        fwdData1 = '0;
        fwdData2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scanIdx = headPtr + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                if ((bus.SrcReg1 != 4'd0) && (regMem[scanIdx] == bus.SrcReg1)) begin
                    fwdHit1  = 1'b1;
                    fwdData1 = dataMem[scanIdx];
                end
                if ((bus.SrcReg2 != 4'd0) && (regMem[scanIdx] == bus.SrcReg2)) begin
                    fwdHit2  = 1'b1;
                    fwdData2 = dataMem[scanIdx];
                end
            end
        end
    end

    assign bus.ReadyA   = readyA;
    assign bus.ReadyB   = readyB;
    assign bus.WriteReg = deq;
    assign bus.DstReg   = (count != '0) ? regMem[headPtr]  : 4'd0;
    assign bus.DstData  = (count != '0) ? dataMem[headPtr] : 16'd0;
    assign bus.FwdHit1  = fwdHit1;
    assign bus.FwdHit2  = fwdHit2;
    assign bus.FwdData1 = fwdData1;
    assign bus.FwdData2 = fwdData2;
    assign bus.Count    = count;

endmodule
